// File: rtl/adc_seq_reader.sv
// Multi-channel SAR ADC sequencer: convert, shift a sample out MSB first, step the mux, settle.
// Optional build macro ADC_SEQ_TEST_PATTERN_EN replaces adc_sdo data with an incrementing counter.
module adc_seq_reader #(
    parameter int NUM_CH        = 8,
    parameter int DATA_W        = 16,
    parameter int CONV_CYCLES   = 20,
    parameter int SCK_DIV       = 1,
    parameter int SETTLE_CYCLES = 2,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              AD_clk,
    input  logic              reset_n,
    input  logic              run,
    input  logic              adc_sdo,
    output logic              adc_cnv,
    output logic              adc_sck,
    output logic              adc_step,
    output logic              adc_reset,
    output logic [DATA_W-1:0] sample_data,
    output logic [CH_W-1:0]   sample_ch,
    output logic              sample_valid,
    output logic              frame_done,
    output logic              busy
);

    typedef enum logic [2:0] {S_IDLE, S_CONV, S_SHIFT, S_STEP, S_SETTLE} state_e;

    localparam int CNT_MAX = (CONV_CYCLES > SETTLE_CYCLES) ? CONV_CYCLES : SETTLE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int DIV_W   = $clog2(SCK_DIV + 1);
    localparam int BIT_W   = $clog2(DATA_W + 1);

    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(CONV_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(SCK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(DATA_W - 1);
    localparam logic [CH_W-1:0]  CH_LAST     = CH_W'(NUM_CH - 1);

    state_e            state_q, state_d;
    logic              run_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [BIT_W-1:0]  bit_q, bit_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              sck_q, sck_d;
    logic              cnv_q, cnv_d;
    logic              step_q, step_d;
    logic              rst_q, rst_d;
    logic              valid_q, valid_d;
    logic              frame_q, frame_d;
    logic              busy_q, busy_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CH_W-1:0]   sch_q, sch_d;
`ifdef ADC_SEQ_TEST_PATTERN_EN
    logic [DATA_W-1:0] pat_q, pat_d;
`else
    logic [DATA_W-1:0] shreg_q, shreg_d;
`endif

    always_ff @(posedge AD_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            run_q   <= 1'b0;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= '0;
            ch_q    <= '0;
            sck_q   <= 1'b0;
            cnv_q   <= 1'b0;
            step_q  <= 1'b0;
            rst_q   <= 1'b0;
            valid_q <= 1'b0;
            frame_q <= 1'b0;
            busy_q  <= 1'b0;
            data_q  <= '0;
            sch_q   <= '0;
`ifdef ADC_SEQ_TEST_PATTERN_EN
            pat_q   <= '0;
`else
            shreg_q <= '0;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= state_d;
            run_q   <= run;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            ch_q    <= ch_d;
            sck_q   <= sck_d;
            cnv_q   <= cnv_d;
            step_q  <= step_d;
            rst_q   <= rst_d;
            valid_q <= valid_d;
            frame_q <= frame_d;
            busy_q  <= busy_d;
            data_q  <= data_d;
            sch_q   <= sch_d;
`ifdef ADC_SEQ_TEST_PATTERN_EN
            pat_q   <= pat_d;
`else
            shreg_q <= shreg_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every variable gets a default first so no latch is inferred.
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        ch_d    = ch_q;
        sck_d   = sck_q;
        data_d  = data_q;
        sch_d   = sch_q;
        valid_d = 1'b0;
        frame_d = 1'b0;
        step_d  = 1'b0;
        rst_d   = 1'b0;
`ifdef ADC_SEQ_TEST_PATTERN_EN
        pat_d   = pat_q;
`else
        shreg_d = shreg_q;
`endif
        case (state_q)
            S_IDLE: begin
                ch_d = '0;
                if (run_q) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                end
            end
            S_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    div_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    sck_d = ~sck_q;
                    // End of a high phase: take the bit the ADC has been presenting.
                    if (sck_q) begin
`ifndef ADC_SEQ_TEST_PATTERN_EN
                        shreg_d = {shreg_q[DATA_W-2:0], adc_sdo};
`endif
                        if (bit_q == BIT_LAST) begin
                            state_d = S_STEP;
                            valid_d = 1'b1;
                            sch_d   = ch_q;
                            frame_d = (ch_q == CH_LAST);
`ifdef ADC_SEQ_TEST_PATTERN_EN
                            data_d  = pat_q;
                            pat_d   = pat_q + 1'b1;
`else
                            data_d  = {shreg_q[DATA_W-2:0], adc_sdo};
`endif
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            S_STEP: begin
                if (ch_q == CH_LAST) begin
                    rst_d = 1'b1;
                    ch_d  = '0;
                end else begin
                    step_d = 1'b1;
                    ch_d   = ch_q + 1'b1;
                end
                if (SETTLE_CYCLES != 0) begin
                    state_d = S_SETTLE;
                    cnt_d   = '0;
                end else if (run_q) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                end else if (ch_d == '0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LAST;
                end
            end
            S_SETTLE: begin
                if (cnt_q != SETTLE_LAST) begin
                    cnt_d = cnt_q + 1'b1;
                end else if (run_q) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                end else if (ch_q != '0) begin
                    // Stopping mid-frame: rewind the mux, then one more settle cycle before IDLE.
                    rst_d = 1'b1;
                    ch_d  = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        cnv_d  = (state_d == S_CONV);
        busy_d = (state_d != S_IDLE);
    end

    assign adc_cnv      = cnv_q;
    assign adc_sck      = sck_q;
    assign adc_step     = step_q;
    assign adc_reset    = rst_q;
    assign sample_data  = data_q;
    assign sample_ch    = sch_q;
    assign sample_valid = valid_q;
    assign frame_done   = frame_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_adc_seq_reader.sv
// Directed bench for adc_seq_reader: instance a (4ch, 16b, SCK_DIV=1), instance b (4ch, 12b, SCK_DIV=3).
module tb_adc_seq_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n = 1'b0;
    logic        run_a = 1'b0, run_b = 1'b0;
    logic        sdo_a;
    logic        sdo_b = 1'b0;
    logic        cnv_a, sck_a, step_a, rst_a, valid_a, fd_a, busy_a;
    logic [15:0] data_a;
    logic [1:0]  ch_a;
    logic        cnv_b, sck_b, step_b, rst_b, valid_b, fd_b, busy_b;
    logic [11:0] data_b;
    logic [1:0]  ch_b;

    int n_checks = 0;
    int n_pass   = 0;
    int sv_total = 0;

    adc_seq_reader #(.NUM_CH(4), .DATA_W(16), .CONV_CYCLES(20), .SCK_DIV(1), .SETTLE_CYCLES(2)) dut_a (
        .AD_clk(clk), .reset_n(reset_n), .run(run_a), .adc_sdo(sdo_a),
        .adc_cnv(cnv_a), .adc_sck(sck_a), .adc_step(step_a), .adc_reset(rst_a),
        .sample_data(data_a), .sample_ch(ch_a), .sample_valid(valid_a),
        .frame_done(fd_a), .busy(busy_a)
    );

    adc_seq_reader #(.NUM_CH(4), .DATA_W(12), .CONV_CYCLES(20), .SCK_DIV(3), .SETTLE_CYCLES(2)) dut_b (
        .AD_clk(clk), .reset_n(reset_n), .run(run_b), .adc_sdo(sdo_b),
        .adc_cnv(cnv_b), .adc_sck(sck_b), .adc_step(step_b), .adc_reset(rst_b),
        .sample_data(data_b), .sample_ch(ch_b), .sample_valid(valid_b),
        .frame_done(fd_b), .busy(busy_b)
    );

    // ADC model for instance a: a conversion rewinds the word, each sck fall presents the next bit.
    logic [15:0] adc_word = 16'hA5C3;
    logic [4:0]  bit_idx = 5'd0;
    logic        sck_prev_a = 1'b0;
    always @(negedge clk) begin
        if (cnv_a) bit_idx <= 5'd0;
        else if (sck_prev_a && !sck_a && bit_idx < 5'd16) bit_idx <= bit_idx + 5'd1;
        sck_prev_a <= sck_a;
    end
    assign sdo_a = (bit_idx < 5'd16) ? adc_word[15 - bit_idx] : 1'b0;

    // Instance b sees a square wave toggling every 6 clocks.
    int tog = 0;
    always @(negedge clk) begin
        tog <= (tog == 5) ? 0 : tog + 1;
        if (tog == 5) sdo_b <= ~sdo_b;
    end

    function automatic logic [15:0] exp_a(input int idx);
`ifdef ADC_SEQ_TEST_PATTERN_EN
        return 16'(idx);
`else
        return 16'hA5C3;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_idle_a(output int saw_rst);
        saw_rst = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (rst_a) saw_rst = 1;
            if (valid_a) sv_total++;
            if (!busy_a) break;
        end
    endtask

    initial begin
        int first_sv, last_sv, n_sv, n_step, n_rst, n_fd, bad_fd, bad_data, bad_gap;
        int cnv0, cnv1, saw_rst, sv_t, step_t, rst_t, low_t, last_ch;
        int prev_sck, run_len, seen_rise, phase_err, rises1, rises2, sv1, sv2, bad_b, nb;
        logic [9:0] ch_trace;

        repeat (3) @(negedge clk);
        check("reset_outputs", {cnv_a, sck_a, step_a, rst_a, valid_a, fd_a, busy_a, ch_a, data_a}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Continuous run: one full frame plus the first slot of the next.
        run_a = 1'b1;
        first_sv = -1; last_sv = -1; n_sv = 0; n_step = 0; n_rst = 0; n_fd = 0;
        bad_fd = 0; bad_data = 0; bad_gap = 0; ch_trace = '0; cnv0 = -1; cnv1 = -1;
        for (int t = 0; t <= 273; t++) begin
            @(negedge clk);
            if (t == 0) cnv0 = int'(cnv_a);
            if (t == 1) cnv1 = int'(cnv_a);
            if (valid_a) begin
                if (n_sv == 0) first_sv = t;
                else if (t - last_sv != 55) bad_gap++;
                last_sv = t;
                ch_trace = {ch_trace[7:0], ch_a};
                if (data_a !== exp_a(sv_total)) bad_data++;
                if (fd_a !== (ch_a == 2'd3)) bad_fd++;
                n_sv++;
                sv_total++;
            end
            if (step_a) n_step++;
            if (rst_a) n_rst++;
            if (fd_a) n_fd++;
        end
        check("cnv_edge0", cnv0, 0);
        check("cnv_edge1", cnv1, 1);
        check("first_valid_edge", first_sv, 53);
        check("valid_count", n_sv, 5);
        check("valid_period", bad_gap, 0);
        check("ch_sequence", ch_trace, 10'b00_01_10_11_00);
        check("sample_data", bad_data, 0);
        check("step_pulses", n_step, 3);
        check("reset_pulses", n_rst, 1);
        check("frame_done_count", n_fd, 1);
        check("frame_done_align", bad_fd, 0);
        run_a = 1'b0;
        wait_idle_a(saw_rst);
        check("stop_idle", busy_a, 0);
        check("stop_rewind", saw_rst, 1);

        // One-cycle run pulse: exactly one slot, then rewind and IDLE.
        @(negedge clk);
        run_a = 1'b1;
        sv_t = -1; step_t = -1; rst_t = -1; low_t = -1; n_sv = 0; last_ch = -1; bad_data = 0;
        for (int t = 0; t <= 62; t++) begin
            @(negedge clk);
            run_a = 1'b0;
            if (valid_a) begin
                sv_t = t; last_ch = int'(ch_a); n_sv++;
                if (data_a !== exp_a(sv_total)) bad_data++;
                sv_total++;
            end
            if (step_a && step_t < 0) step_t = t;
            if (rst_a && rst_t < 0) rst_t = t;
            if (t > 0 && !busy_a && low_t < 0) low_t = t;
        end
        check("pulse_valid_edge", sv_t, 53);
        check("pulse_valid_ch", last_ch, 0);
        check("pulse_valid_count", n_sv, 1);
        check("pulse_data", bad_data, 0);
        check("pulse_step_edge", step_t, 54);
        check("pulse_reset_edge", rst_t, 56);
        check("pulse_busy_low", low_t, 57);

        // Drop run during the shift of channel 2: that slot still completes.
        run_a = 1'b1;
        n_sv = 0; last_ch = -1; step_t = -1; rst_t = -1; low_t = -1; bad_data = 0;
        for (int t = 0; t <= 175; t++) begin
            @(negedge clk);
            if (t == 140) run_a = 1'b0;
            if (valid_a) begin
                last_ch = int'(ch_a); n_sv++;
                if (data_a !== exp_a(sv_total)) bad_data++;
                sv_total++;
            end
            if (step_a) step_t = t;
            if (rst_a && rst_t < 0) rst_t = t;
            if (t > 0 && !busy_a && low_t < 0) low_t = t;
        end
        check("drop_valid_count", n_sv, 3);
        check("drop_last_ch", last_ch, 2);
        check("drop_data", bad_data, 0);
        check("drop_step_edge", step_t, 164);
        check("drop_reset_edge", rst_t, 166);
        check("drop_busy_low", low_t, 167);

        // Asynchronous reset in the middle of a conversion.
        run_a = 1'b1;
        repeat (10) @(negedge clk);
        check("pre_reset_cnv", cnv_a, 1);
        #2 reset_n = 1'b0;
        #1 check("async_reset_outputs", {cnv_a, sck_a, step_a, rst_a, valid_a, fd_a, busy_a, ch_a, data_a}, 32'd0);
        sv_total = 0;
        @(negedge clk);
        reset_n = 1'b1;
        sv_t = -1; last_ch = -1;
        for (int t = 0; t <= 60; t++) begin
            @(negedge clk);
            if (valid_a && sv_t < 0) begin
                sv_t = t; last_ch = int'(ch_a);
                check("post_reset_data", data_a, exp_a(sv_total));
                sv_total++;
            end
        end
        check("post_reset_valid_edge", sv_t, 53);
        check("post_reset_ch", last_ch, 0);
        run_a = 1'b0;
        wait_idle_a(saw_rst);

        // Instance b: 3-cycle sck phases, 12 bits, 95-cycle slot, alternating data.
        run_b = 1'b1;
        prev_sck = 0; run_len = 0; seen_rise = 0; phase_err = 0; rises1 = 0; rises2 = 0;
        sv1 = -1; sv2 = -1; bad_b = 0; nb = 0;
        for (int t = 0; t <= 190; t++) begin
            @(negedge clk);
            if (int'(sck_b) != prev_sck) begin
                if (prev_sck == 1 && run_len != 3) phase_err++;
                if (prev_sck == 0 && seen_rise == 1 && run_len != 3) phase_err++;
                if (sck_b) begin
                    seen_rise = 1;
                    if (sv1 < 0) rises1++; else if (sv2 < 0) rises2++;
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            prev_sck = int'(sck_b);
            if (valid_b) begin
                seen_rise = 0;
                if (sv1 < 0) sv1 = t; else if (sv2 < 0) sv2 = t;
`ifdef ADC_SEQ_TEST_PATTERN_EN
                if (data_b !== 12'(nb)) bad_b++;
`else
                if (data_b !== 12'hAAA && data_b !== 12'h555) bad_b++;
`endif
                nb++;
            end
        end
        run_b = 1'b0;
        check("b_first_valid_edge", sv1, 93);
        check("b_second_valid_edge", sv2, 188);
        check("b_sck_phase_len", phase_err, 0);
        check("b_pulses_slot0", rises1, 12);
        check("b_pulses_slot1", rises2, 12);
        check("b_sample_data", bad_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_seq_reader.md
# adc_seq_reader

Parametrised multi-channel sequencer for the serial SAR ADC on the acquisition board, running in the `AD_clk` domain. It is the generalised successor of the fixed single-channel ADC readout. Each channel slot:
- pulses `adc_cnv`;
- clocks out a `DATA_W`-bit sample on `adc_sck`/`adc_sdo`, MSB first;
- advances the analog front-end mux with `adc_step`.

After `NUM_CH` slots it pulses `adc_reset` to rewind the mux. Samples are presented with channel tags to the downstream FIFO/pipe logic, which has no backpressure.

## Interface
Parameters:
- `NUM_CH`, 8: channels per frame, 1–64.
- `DATA_W`, 16: bits per sample, 2–32.
- `CONV_CYCLES`, 20: `AD_clk` cycles `adc_cnv` is held high, ≥1.
- `SCK_DIV`, 1: `AD_clk` cycles per `adc_sck` half-period, ≥1.
- `SETTLE_CYCLES`, 2: idle cycles after each step/reset pulse, ≥0.

Ports:
- `AD_clk`, in, 1: sole clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `run`, in, 1: level; high = acquire frames continuously.
- `adc_sdo`, in, 1: ADC serial data.
- `adc_cnv`, out, 1: conversion start.
- `adc_sck`, out, 1: serial clock.
- `adc_step`, out, 1: advance mux one channel.
- `adc_reset`, out, 1: rewind mux to channel 0.
- `sample_data`, out, `DATA_W`: last captured sample.
- `sample_ch`, out, `$clog2(NUM_CH)` (min 1): channel of `sample_data`.
- `sample_valid`, out, 1: one-cycle strobe.
- `frame_done`, out, 1: one-cycle strobe, coincident with the last channel's `sample_valid`.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- States: IDLE, CONV, SHIFT, STEP, SETTLE.
- **IDLE:** all strobes low, channel index 0. Leaves to CONV when `run` is sampled high.
- **CONV:** `adc_cnv` = 1 for exactly `CONV_CYCLES` cycles, then SHIFT.
- **SHIFT:**
  - `adc_sck` starts low.
  - Each bit is `SCK_DIV` cycles low, then `SCK_DIV` cycles high.
  - `adc_sdo` is sampled on the last cycle of each high phase and shifted in MSB first.
  - After `DATA_W` bits, `sample_data`, `sample_ch` and `sample_valid` are registered, then STEP.
- **STEP:** one cycle.
  - If channel < `NUM_CH-1`: `adc_step` = 1 and channel increments.
  - Otherwise: `adc_reset` = 1 and channel wraps to 0. `frame_done` has already been asserted together with that channel's `sample_valid`.
- **SETTLE:** `SETTLE_CYCLES` cycles with all outputs idle.
  - Exit to CONV if `run` = 1.
  - Otherwise exit to IDLE; when not at channel 0, `adc_reset` is pulsed for one cycle on the way to IDLE.
- **`run` deasserted mid-slot:** the current slot always completes (conversion, shift, strobe, step). `run` is checked only at the SETTLE exit. A sample is never truncated.
- **`run` reasserted during SETTLE:** acquisition continues seamlessly at the next channel.
- **No backpressure:** `sample_data` holds its value until the next `sample_valid`.

## Timing
- Reset values: `adc_cnv`, `adc_sck`, `adc_step`, `adc_reset`, `sample_valid`, `frame_done`, `busy` = 0; `sample_data` = 0; `sample_ch` = 0; state = IDLE; shift register and counters = 0.
- Asserting `reset_n` low mid-slot forces reset values immediately.
- `run` sampled high at edge 0 gives `adc_cnv` = 1 from edge 1.
- `sample_valid` asserts at edge `1 + CONV_CYCLES + 2*SCK_DIV*DATA_W`.
- Slot period: `P = CONV_CYCLES + 2*SCK_DIV*DATA_W + 1 + SETTLE_CYCLES`. Frame period is `NUM_CH*P`.
- `adc_step`/`adc_reset` assert the cycle after `sample_valid`.
- All outputs are registered; no combinational path from input to output.

## Configuration
- `ADC_SEQ_TEST_PATTERN_EN`:
  - **Defined:** `adc_sdo` is ignored. Each captured sample is instead an internal `DATA_W`-bit counter that starts at 0 after reset, increments after every `sample_valid`, and wraps modulo 2^`DATA_W`. All pin timing is unchanged.
  - **Undefined:** samples come from `adc_sdo`, and the counter logic is absent.

## Test plan
Parameters unless stated: `NUM_CH`=4, `DATA_W`=16, `CONV_CYCLES`=20, `SCK_DIV`=1, `SETTLE_CYCLES`=2, so P=55.
- `run` held high, `adc_sdo` driven by a model returning `16'hA5C3` ->
  - `sample_valid` every 55 cycles, `sample_data` = A5C3;
  - `sample_ch` 0,1,2,3,0;
  - 3 `adc_step` pulses, then 1 `adc_reset` pulse per frame;
  - `frame_done` only with ch 3.
- `run` pulsed high for 1 cycle -> exactly one slot:
  - ch 0 sample, `adc_step`, then `adc_reset` on return to IDLE;
  - `busy` low 57 cycles after start.
- `run` dropped during SHIFT of ch 2 -> ch 2 sample still delivered with correct data, `adc_step`, then `adc_reset`, then IDLE.
- `reset_n` low during CONV -> all outputs 0 asynchronously, before the next `AD_clk` edge. After release with `run` high, the first sample is ch 0.
- `SCK_DIV`=3, `DATA_W`=12 -> `adc_sck` high and low phases of 3 cycles each, 12 pulses, P=95; `adc_sdo` toggling every 6 cycles yields 12'hAAA or 12'h555 consistently.
- `ADC_SEQ_TEST_PATTERN_EN` defined -> `sample_data` sequence 0,1,2,…; at `DATA_W`=2 it wraps 3→0.
